// File: rtl/apb_multi_master.sv
// apb_multi_master: bridges a host request onto an APB bus with NUM_SLAVES slaves.
// Runs SETUP/ACCESS phases, supports back-to-back transfers, aborts on a PREADY
// timeout and reports a coded error with a one-cycle done pulse.
module apb_multi_master #(
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         pclk,
    input  logic                         rst_n,
    input  logic                         transfer,
    input  logic                         pwrite_in,
    input  logic [SEL_W-1:0]             sel_in,
    input  logic [ADDR_W-1:0]            addr_in,
    input  logic [DATA_W-1:0]            wdata_in,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_W-1:0]            rdata_out,
    output logic                         err,
    output logic [2:0]                   err_code
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // A zero timeout still needs a legal (unused) counter width.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [2:0] ErrOk  = 3'b000;
    localparam logic [2:0] ErrSel = 3'b001;
    localparam logic [2:0] ErrTmo = 3'b010;
    localparam logic [2:0] ErrSlv = 3'b011;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e                  state;
    logic [IDX_W-1:0]        sel_idx;
    logic [CNT_W-1:0]        tmo_cnt;

    logic                    sel_ok;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic [IDX_W-1:0]        sel_in_idx;
    logic                    pready_s;
    logic                    pslverr_s;
    logic [DATA_W-1:0]       prdata_s;
    logic                    tmo_hit;

    // Decode the host select: valid range is 1..NUM_SLAVES, slave k-1 addressed.
    always_comb begin
        sel_ok     = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_in == SEL_W'(i + 1)) begin
                sel_ok        = 1'b1;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_in_idx = IDX_W'(sel_in - SEL_W'(1));

    // Only the currently addressed slave's response is looked at.
    assign pready_s  = pready[sel_idx];
    assign pslverr_s = pslverr[sel_idx];
    assign prdata_s  = prdata[sel_idx*DATA_W +: DATA_W];

    // Fires on the ACCESS edge that would make TIMEOUT_CYCLES consecutive not-ready cycles.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && !pready_s &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Transfer FSM with all host/APB outputs registered.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            sel_idx   <= '0;
            tmo_cnt   <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata_out <= '0;
            err       <= 1'b0;
            err_code  <= ErrOk;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (transfer) begin
                        if (sel_ok) begin
                            pwrite  <= pwrite_in;
                            paddr   <= addr_in;
                            pwdata  <= wdata_in;
                            sel_idx <= sel_in_idx;
                            psel    <= sel_onehot;
                            penable <= 1'b0;
                            busy    <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= StSetup;
                        end else begin
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= ErrSel;
                        end
                    end
                end

                StSetup: begin
                    penable <= 1'b1;
                    state   <= StAccess;
                end

                StAccess: begin
                    if (pready_s || tmo_hit) begin
                        done <= 1'b1;
                        // Normal completion wins over a simultaneous timeout.
                        if (pready_s) begin
                            err      <= pslverr_s;
                            err_code <= pslverr_s ? ErrSlv : ErrOk;
                            if (!pwrite) begin
                                rdata_out <= prdata_s;
                            end
                        end else begin
                            err      <= 1'b1;
                            err_code <= ErrTmo;
                        end
                        // A valid follow-on request skips IDLE; an invalid one is
                        // reported from IDLE on the next edge so the two done pulses
                        // do not collide.
                        if (transfer && sel_ok) begin
                            pwrite  <= pwrite_in;
                            paddr   <= addr_in;
                            pwdata  <= wdata_in;
                            sel_idx <= sel_in_idx;
                            psel    <= sel_onehot;
                            penable <= 1'b0;
                            busy    <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= StSetup;
                        end else begin
                            psel    <= '0;
                            penable <= 1'b0;
                            busy    <= 1'b0;
                            state   <= StIdle;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    psel    <= '0;
                    penable <= 1'b0;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_multi_master.md
Name: apb_multi_master

Overview:
Parametrised APB master bridge, the successor to the fixed two-slave (GPIO/UART) APB front end. It takes a host request (transfer, direction, slave select, address, data) and runs standard APB SETUP/ACCESS phases to one of NUM_SLAVES slaves. Features added over the previous front end:
- generic slave count, address width and data width;
- back-to-back transfers;
- a programmable PREADY timeout;
- a coded error report to the host.

Parameters:
NUM_SLAVES, 2, number of APB slaves; select value k (1..NUM_SLAVES) addresses slave k-1
SEL_W, 2, width of host select field; must satisfy 2^SEL_W > NUM_SLAVES
ADDR_W, 5, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYCLES, 16, maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
pclk  input  1  APB clock; all logic on its rising edge
Reset  input  1  asynchronous, active-low reset
transfer  input  1  host request valid
pwrite_in  input  1  host direction: 1 = write, 0 = read
sel_in  input  SEL_W  host slave select; 0 or >NUM_SLAVES is invalid
addr_in  input  ADDR_W  host address
wdata_in  input  DATA_W  host write data
psel  output  NUM_SLAVES  one-hot APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  NUM_SLAVES*DATA_W  slave read data, concatenated; slave i occupies bits [i*DATA_W +: DATA_W]
pready  input  NUM_SLAVES  per-slave ready
pslverr  input  NUM_SLAVES  per-slave error
busy  output  1  high whenever the FSM is not IDLE
done  output  1  one-cycle completion pulse
rdata_out  output  DATA_W  last read data
err  output  1  valid with done: transfer failed
err_code  output  3  valid with done; holds its value until the next done

Behaviour:
- Reset low, asynchronous: FSM goes to IDLE. All outputs go to 0 immediately: psel, penable, pwrite, paddr, pwdata, busy, done, rdata_out, err, err_code. The timeout counter clears. A transfer in progress is dropped with no done pulse.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, transfer=1, sel_in valid at a rising edge:
  - capture pwrite_in, addr_in, wdata_in and sel_in into pwrite, paddr, pwdata and the internal select;
  - go to SETUP.
- IDLE, transfer=1, sel_in invalid at a rising edge:
  - no APB activity; stay in IDLE;
  - next cycle: done=1, err=1, err_code=001;
  - if transfer stays high with an invalid select, this repeats every cycle.
- SETUP (exactly 1 cycle): psel[k-1]=1, penable=0. Go to ACCESS.
- ACCESS: psel[k-1]=1, penable=1. The timeout counter increments on every edge where pready[k-1]=0.
- Completion edge (ACCESS and pready[k-1]=1):
  - next cycle: done=1;
  - err and err_code come from pslverr[k-1]: err=1 and err_code=011 if set, otherwise err=0 and err_code=000;
  - on a read, rdata_out latches prdata slice k-1 regardless of pslverr; on a write, rdata_out is unchanged.
- Timeout, when TIMEOUT_CYCLES>0:
  - triggered on the edge where pready has been low for TIMEOUT_CYCLES consecutive ACCESS cycles;
  - FSM aborts to IDLE; psel and penable drop next cycle;
  - next cycle: done=1, err=1, err_code=010; rdata_out is unchanged.
- If pready=1 on the same edge the timeout would fire, normal completion wins.
- After completion or timeout: if transfer=1 on that same edge, capture the new request and go straight to SETUP.
  - psel stays high (or switches slave) with penable=0 for that cycle.
  - An invalid select in this case behaves as in IDLE.
  - If transfer=0, go to IDLE.
- Outside SETUP/ACCESS, psel=0 and penable=0. pwrite, paddr and pwdata hold their last captured values; they change only on a capture edge, so they are stable across SETUP and ACCESS.
- Host inputs are ignored while the FSM is in SETUP, or in ACCESS before the completion or timeout edge.
- Error codes: 000 ok, 001 invalid select, 010 timeout, 011 slave PSLVERR; 1xx reserved.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP.
- Unselected slaves' pready, pslverr and prdata are ignored.

Test Plan:
1. Write, NUM_SLAVES=2, sel_in=1, addr=1, wdata=ABCD1234, slave 0 pready tied high:
   - psel=01 for 2 cycles; penable high only in the 2nd;
   - done one cycle later with err=0, err_code=000.
2. Read, sel_in=2, addr=2, slave 1 holds pready low for 2 ACCESS cycles and returns 00000AAA:
   - ACCESS lasts 3 cycles;
   - rdata_out=00000AAA and done=1 the cycle after pready.
3. sel_in=0, then sel_in=3 (one cycle each), transfer high:
   - psel stays 00;
   - done with err_code=001 each time.
4. TIMEOUT_CYCLES=4, slave 1 pready held low:
   - abort after 4 ACCESS cycles; done with err_code=010; rdata_out unchanged; busy=0.
5. Slave 0 responds with pready=1 and pslverr=1 on a read of 12345678:
   - err_code=011; rdata_out=12345678.
6. Back-to-back: transfer held high across writes to slaves 1 then 2:
   - psel goes 01 to 10 with no idle cycle between.
   Reset mid-access: Reset pulsed low during ACCESS; all outputs drop to 0 asynchronously, no done pulse, next request starts cleanly from IDLE.
